// File: rtl/hist_prefix_pass.sv
// hist_prefix_pass: histogram + exclusive prefix-sum pre-pass for the image sorter.
// Clears a 256-bin count array, counts one frame of pixels, then streams
// {bin, base, count} per bin, where base is the bin's start address in sorted order.
module hist_prefix_pass #(
  parameter int PIX_W  = 8,
  parameter int PIXELS = 16384,
  parameter int CNT_W  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             off_valid,
  input  logic             off_ready,
  output logic [PIX_W-1:0] off_bin,
  output logic [CNT_W-1:0] off_base,
  output logic [CNT_W-1:0] off_count,
  output logic             busy,
  output logic             done
);

  localparam int BINS = 1 << PIX_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SCAN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [PIX_W-1:0] addr;
  logic [PIX_W-1:0] bin;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] sum;
  logic [CNT_W-1:0] hist [BINS];

  logic accept;
  logic handshake;
  logic last_addr;
  logic last_pix;
  logic last_bin;

  assign pix_ready = (state == ACCUM);
  assign off_valid = (state == SCAN);
  assign busy      = (state == CLEAR) || (state == ACCUM) || (state == SCAN);
  assign done      = (state == DONE);

  assign accept    = pix_valid && pix_ready;
  assign handshake = off_valid && off_ready;
  assign last_addr = (addr == PIX_W'(BINS - 1));
  assign last_pix  = (pcnt == CNT_W'(PIXELS - 1));
  assign last_bin  = (bin == PIX_W'(BINS - 1));

  // Entry fields are forced to zero outside SCAN so idle outputs stay quiet.
  assign off_bin   = off_valid ? bin       : '0;
  assign off_base  = off_valid ? sum       : '0;
  assign off_count = off_valid ? hist[bin] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   if (last_addr) state_next = ACCUM;
      ACCUM:   if (accept && last_pix) state_next = SCAN;
      SCAN:    if (handshake && last_bin) state_next = DONE;
      DONE:    state_next = start ? CLEAR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear pointer, pixel counter, scan bin and running prefix sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      pcnt <= '0;
      bin  <= '0;
      sum  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) addr <= '0;
        end
        CLEAR: begin
          addr <= addr + 1'b1;
          if (last_addr) pcnt <= '0;
        end
        ACCUM: begin
          if (accept) begin
            pcnt <= pcnt + 1'b1;
            if (last_pix) begin
              bin <= '0;
              sum <= '0;
            end
          end
        end
        SCAN: begin
          if (handshake) begin
            sum <= sum + hist[bin];
            bin <= bin + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Histogram array: zeroed one bin per cycle in CLEAR, single-cycle increment in ACCUM.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      hist[addr] <= '0;
    end else if (accept) begin
      hist[pix_data] <= hist[pix_data] + 1'b1;
    end
  end

endmodule
